// File: rtl/rt_lim_pkg.sv
// rtl/rt_lim_pkg.sv - shared types and LiM operator for the racetrack array
package rt_lim_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    OP_PLAIN = 3'b000,
    OP_AND   = 3'b001,
    OP_OR    = 3'b010,
    OP_XOR   = 3'b011,
    OP_NAND  = 3'b100,
    OP_NOR   = 3'b101,
    OP_XNOR  = 3'b110,
    OP_RSVD  = 3'b111
  } lim_opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } rt_state_e;

  // Plain and the reserved code both pass the stored value through unchanged.
  function automatic logic [31:0] lim_apply(lim_opcode_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/rt_wordline_encoder.sv
// rtl/rt_wordline_encoder.sv - lowest-word priority encoder for packed byte word lines
module rt_wordline_encoder
  import rt_lim_pkg::*;
#(
  parameter int BYTES  = 1024,
  parameter int WIDX_W = 8
) (
  input  logic [BYTES-1:0]  word_lines_i,
  output logic [WIDX_W-1:0] word_idx_o,
  output logic [3:0]        be_o,
  output logic              sel_valid_o
);

  localparam int WORDS = BYTES / 4;

  // Scanning downwards leaves the lowest active word as the final assignment.
  always_comb begin
    word_idx_o  = '0;
    be_o        = '0;
    sel_valid_o = 1'b0;
    for (int w = WORDS - 1; w >= 0; w--) begin
      if (|word_lines_i[4*w +: 4]) begin
        word_idx_o  = WIDX_W'(w);
        be_o        = word_lines_i[4*w +: 4];
        sel_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rt_lim_array.sv
// rtl/rt_lim_array.sv - cycle-approximate racetrack logic-in-memory array
module rt_lim_array
  import rt_lim_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int BYTES         = 2**ADDR_WIDTH,
  parameter int DOMAINS       = 32,
  parameter int SHIFT_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_b_int_i,
  input  logic             we_b_i,
  input  logic [BYTES-1:0] word_lines_i,
  input  logic [2:0]       opcode_mem_i,
  input  logic [31:0]      mask_i,
  input  logic [31:0]      wdata_b_i,
  output logic [31:0]      rdata_b_o,
  output logic             rvalid_rt_o
);

  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam int POS_W  = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;

  logic [7:0] RT_mem [BYTES];

  logic [WIDX_W-1:0] enc_idx;
  logic [3:0]        enc_be;
  logic              enc_valid;

  rt_wordline_encoder #(
    .BYTES  (BYTES),
    .WIDX_W (WIDX_W)
  ) u_encoder (
    .word_lines_i (word_lines_i),
    .word_idx_o   (enc_idx),
    .be_o         (enc_be),
    .sel_valid_o  (enc_valid)
  );

  rt_state_e         state_q, state_d;
  logic [POS_W-1:0]  head_q, head_d;
  logic [POS_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              we_q, we_d;
  lim_opcode_e       op_q, op_d;
  logic [31:0]       mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [3:0]        be_q, be_d;
  logic              valid_q, valid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [POS_W-1:0] tgt_c, dist_c;
  logic [31:0]      mem_word, applied, wr_word, rd_word;
  logic             access_last, mem_we;

  always_comb begin
    tgt_c  = POS_W'(32'(enc_idx) % 32'(DOMAINS));
    dist_c = (tgt_c >= head_q) ? (tgt_c - head_q) : (head_q - tgt_c);
  end

  always_comb begin
    mem_word = '0;
    for (int k = 0; k < 4; k++) begin
      mem_word[8*k +: 8] = RT_mem[{widx_q, 2'(k)}];
    end
  end

  always_comb begin
    applied = lim_apply(op_q, mem_word, mask_q);
    wr_word = (op_q == OP_PLAIN || op_q == OP_RSVD) ? wdata_q : applied;
    rd_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (be_q[k]) rd_word[8*k +: 8] = applied[8*k +: 8];
    end
  end

  assign access_last = (state_q == ACCESS) && (acc_cnt_q == '0);
  assign mem_we      = rst_ni && access_last && we_q && valid_q;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    acc_cnt_d = acc_cnt_q;
    we_d      = we_q;
    op_d      = op_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    widx_d    = widx_q;
    be_d      = be_q;
    valid_d   = valid_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (en_b_int_i) begin
          we_d      = we_b_i;
          op_d      = lim_opcode_e'(opcode_mem_i);
          mask_d    = mask_i;
          wdata_d   = wdata_b_i;
          widx_d    = enc_idx;
          be_d      = enc_be;
          valid_d   = enc_valid;
          target_d  = tgt_c;
          acc_cnt_d = CNT_W'(ACCESS_CYCLES - 1);
          if (enc_valid && dist_c != '0) begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(32'(dist_c) * 32'(SHIFT_CYCLES) - 32'd1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          head_d  = target_q;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCESS: begin
        if (acc_cnt_q == '0) begin
          rdata_d = (valid_q && !we_q) ? rd_word : '0;
          state_d = DONE;
        end else begin
          acc_cnt_d = acc_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      head_q    <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      acc_cnt_q <= '0;
      we_q      <= 1'b0;
      op_q      <= OP_PLAIN;
      mask_q    <= '0;
      wdata_q   <= '0;
      widx_q    <= '0;
      be_q      <= '0;
      valid_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      acc_cnt_q <= acc_cnt_d;
      we_q      <= we_d;
      op_q      <= op_d;
      mask_q    <= mask_d;
      wdata_q   <= wdata_d;
      widx_q    <= widx_d;
      be_q      <= be_d;
      valid_q   <= valid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately left unreset; only the final access cycle writes it.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) RT_mem[{widx_q, 2'(k)}] <= wr_word[8*k +: 8];
      end
    end
  end

  assign rvalid_rt_o = (state_q == DONE);
  assign rdata_b_o   = (state_q == DONE) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_rt_lim_array.sv
// tb/tb_rt_lim_array.sv - scoreboard bench for rt_lim_array against a word-level model
module tb_rt_lim_array;

  localparam int AW  = 10;
  localparam int NB  = 1024;
  localparam int NW  = NB / 4;
  localparam int DOM = 32;
  localparam int SC  = 2;
  localparam int AC  = 1;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          en_b_int_i;
  logic          we_b_i;
  logic [NB-1:0] word_lines_i;
  logic [2:0]    opcode_mem_i;
  logic [31:0]   mask_i;
  logic [31:0]   wdata_b_i;
  logic [31:0]   rdata_b_o;
  logic          rvalid_rt_o;

  always #5 clk = ~clk;

  rt_lim_array #(
    .ADDR_WIDTH    (AW),
    .DOMAINS       (DOM),
    .SHIFT_CYCLES  (SC),
    .ACCESS_CYCLES (AC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_b_int_i   (en_b_int_i),
    .we_b_i       (we_b_i),
    .word_lines_i (word_lines_i),
    .opcode_mem_i (opcode_mem_i),
    .mask_i       (mask_i),
    .wdata_b_i    (wdata_b_i),
    .rdata_b_o    (rdata_b_o),
    .rvalid_rt_o  (rvalid_rt_o)
  );

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    string       name;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          accept_cyc = 0;
  bit          after_done = 0;
  logic [7:0]  mem_m [NB];
  int          head_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      1: return a & b;
      2: return a | b;
      3: return a ^ b;
      4: return ~(a & b);
      5: return ~(a | b);
      6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {mem_m[4*w+3], mem_m[4*w+2], mem_m[4*w+1], mem_m[4*w]};
  endfunction

  always @(negedge clk) begin
    if (rst_ni && rvalid_rt_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rvalid: got rvalid=1 expected no outstanding request");
      end else begin
        mon_e = sb.pop_front();
        check32({mon_e.name, "_rdata"}, rdata_b_o, mon_e.rdata);
        check_int({mon_e.name, "_latency"}, cyc - accept_cyc, mon_e.lat);
      end
    end
  end

  // noise >= 0 additionally lights every byte of a higher word that must be ignored.
  task automatic issue(input string name, input bit we, input int w, input logic [3:0] be,
                       input int op, input logic [31:0] mask, input logic [31:0] wdata,
                       input int noise, input bit hold_en);
    exp_t        e;
    logic [31:0] cur, res;
    int          tgt, d;
    bit          got;
    e.name = name;
    e.rdata = '0;
    if (be == 4'h0) begin
      e.lat = AC;
    end else begin
      tgt = w % DOM;
      d = (tgt > head_m) ? tgt - head_m : head_m - tgt;
      head_m = tgt;
      e.lat = d * SC + AC;
      cur = model_word(w);
      res = ref_op(op, cur, mask);
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          if (we) mem_m[4*w+k] = (op == 0 || op == 7) ? wdata[8*k +: 8] : res[8*k +: 8];
          else    e.rdata[8*k +: 8] = (op == 0 || op == 7) ? cur[8*k +: 8] : res[8*k +: 8];
        end
      end
    end
    we_b_i = we;
    opcode_mem_i = op[2:0];
    mask_i = mask;
    wdata_b_i = wdata;
    word_lines_i = '0;
    if (be != 4'h0) word_lines_i[4*w +: 4] = be;
    if (noise >= 0) word_lines_i[4*noise +: 4] = 4'hF;
    en_b_int_i = 1'b1;
    sb.push_back(e);
    if (after_done) @(posedge clk);
    @(posedge clk);
    #1 accept_cyc = cyc;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rvalid_rt_o) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no rvalid expected one within 400 cycles", name);
      sb.delete();
    end
    after_done = 1;
    if (!hold_en) en_b_int_i = 1'b0;
  endtask

  initial begin
    int          w, noise, op;
    logic [3:0]  be;
    logic [31:0] old30;
    rst_ni = 1'b0;
    en_b_int_i = 1'b0;
    we_b_i = 1'b0;
    word_lines_i = '0;
    opcode_mem_i = '0;
    mask_i = '0;
    wdata_b_i = '0;
    repeat (3) @(negedge clk);
    check32("reset_rdata", rdata_b_o, 32'h0);
    check32("reset_rvalid", {31'h0, rvalid_rt_o}, 32'h0);
    check_int("reset_head", int'(dut.head_q), 0);
    rst_ni = 1'b1;
    @(negedge clk);

    issue("wr_w0", 1, 0, 4'hF, 0, 32'h0, 32'hDEADBEEF, -1, 0);
    issue("rd_w0", 0, 0, 4'hF, 0, 32'h0, 32'h0, -1, 0);

    for (int i = 1; i < NW; i++) issue("init", 1, i, 4'hF, 0, 32'h0, $urandom, -1, 0);
    issue("rd_home", 0, 0, 4'hF, 0, 32'h0, 32'h0, -1, 0);

    issue("rd_w5", 0, 5, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    issue("rd_w3", 0, 3, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    check_int("head_after_w3", int'(dut.head_q), 3);

    issue("wr_w7", 1, 7, 4'hF, 0, 32'h0, 32'hF0F0F0F0, -1, 0);
    issue("xor_w7", 1, 7, 4'b1100, 3, 32'hFFFF0000, 32'h0, -1, 0);
    issue("rd_w7", 0, 7, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    check32("xor_result_w7", model_word(7), 32'h0F0FF0F0);

    issue("wr_w8", 1, 8, 4'hF, 0, 32'h0, 32'h12345678, -1, 0);
    issue("and_rd_w8", 0, 8, 4'b0011, 1, 32'h00FF00FF, 32'h0, -1, 0);
    issue("rd_w8", 0, 8, 4'hF, 0, 32'h0, 32'h0, -1, 0);

    issue("range_w4", 1, 4, 4'hF, 2, 32'h1, 32'h0, -1, 1);
    issue("range_w5", 1, 5, 4'hF, 2, 32'h1, 32'h0, -1, 1);
    issue("range_w6", 1, 6, 4'hF, 2, 32'h1, 32'h0, -1, 0);
    for (int i = 4; i < 7; i++) check32("range_bit0", {31'h0, dut.RT_mem[4*i][0]}, 32'h1);

    issue("no_sel", 1, 9, 4'h0, 0, 32'h0, 32'hFFFFFFFF, -1, 0);
    issue("prio_wr", 1, 10, 4'b0101, 0, 32'h0, 32'hA1B2C3D4, 40, 0);
    issue("prio_rd40", 0, 40, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    issue("prio_rd10", 0, 10, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    issue("rsvd_wr", 1, 11, 4'hF, 7, 32'hFFFFFFFF, 32'h55AA33CC, -1, 0);
    issue("rsvd_rd", 0, 11, 4'hF, 7, 32'hFFFFFFFF, 32'h0, -1, 0);

    for (int i = 0; i < 60; i++) begin
      w = int'($urandom % NW);
      be = 4'($urandom);
      op = int'($urandom % 8);
      noise = -1;
      if (be != 4'h0 && w < NW - 1 && ($urandom % 4) == 0) noise = w + 1 + int'($urandom % (NW - 1 - w));
      issue("rand", 1'($urandom), w, be, op, $urandom, $urandom, noise, 0);
    end

    issue("rd_home2", 0, 0, 4'hF, 0, 32'h0, 32'h0, -1, 0);
    old30 = model_word(30);
    @(posedge clk);
    @(negedge clk);
    after_done = 0;
    we_b_i = 1'b1;
    opcode_mem_i = 3'b000;
    wdata_b_i = ~old30;
    word_lines_i = '0;
    word_lines_i[4*30 +: 4] = 4'hF;
    en_b_int_i = 1'b1;
    @(negedge clk);
    en_b_int_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    check32("rst_mid_rdata", rdata_b_o, 32'h0);
    check_int("rst_mid_head", int'(dut.head_q), 0);
    rst_ni = 1'b1;
    head_m = 0;
    repeat (80) @(negedge clk);
    check32("rst_mid_mem", {dut.RT_mem[123], dut.RT_mem[122], dut.RT_mem[121], dut.RT_mem[120]}, old30);
    issue("rd_w30_after_rst", 0, 30, 4'hF, 0, 32'h0, 32'h0, -1, 0);

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
